// File: rtl/gamepad_poll_scheduler.sv
// Two-pad poll scheduler: shared scan engine, per-pad debounce, sticky press events, Avalon-MM regs.
// Optional GAMEPAD_POLL_IRQ_EN: when defined, irq and the RW irq_en control bit are implemented.
module gamepad_poll_scheduler #(
    parameter int POLL_PERIOD  = 1666667,
    parameter int DEBOUNCE     = 2,
    parameter int SCAN_TIMEOUT = 16383
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        scan_req,
    output logic        scan_sel,
    input  logic        scan_done,
    input  logic [11:0] scan_btn,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = $clog2(SCAN_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_UPD  = 2'd3;

    logic [PW-1:0]     poll_cnt;
    logic              tick;
    logic [1:0]        state;
    logic              pad;
    logic [TW-1:0]     tcnt;
    logic              timed_out;
    logic [11:0]       sample;
    logic [1:0][11:0]  stable, last, evt, evt_set, evt_clr;
    logic [1:0][3:0]   cnt;
    logic [1:0]        present;
    logic [7:0]        frame;
    logic              enable, irq_en;
    logic              same, upd_ok;
    logic [3:0]        cnt_nx;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign unused_bits = ^{avs_writedata[31:28], avs_writedata[15:12], avs_writedata[1]};
    assign tick     = (poll_cnt == PW'(POLL_PERIOD - 1));
    assign scan_req = (state == S_REQ);
    assign scan_sel = pad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) poll_cnt <= '0;
        else        poll_cnt <= tick ? '0 : poll_cnt + PW'(1);
    end

    // A tick seen outside IDLE is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pad       <= 1'b0;
            tcnt      <= '0;
            timed_out <= 1'b0;
            sample    <= '0;
            frame     <= '0;
        end else begin
            case (state)
                S_IDLE: if (tick && enable) begin
                    state <= S_REQ;
                    pad   <= 1'b0;
                end
                S_REQ: begin
                    state <= S_WAIT;
                    tcnt  <= '0;
                end
                S_WAIT: begin
                    if (scan_done) begin
                        sample    <= scan_btn;
                        timed_out <= 1'b0;
                        state     <= S_UPD;
                    end else if (tcnt == TW'(SCAN_TIMEOUT)) begin
                        timed_out <= 1'b1;
                        state     <= S_UPD;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    if (!pad) begin
                        pad   <= 1'b1;
                        state <= S_REQ;
                    end else begin
                        pad   <= 1'b0;
                        state <= S_IDLE;
                        frame <= frame + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        same    = (sample == last[pad]);
        cnt_nx  = !same ? 4'd0 : ((cnt[pad] == 4'hF) ? 4'hF : cnt[pad] + 4'd1);
        upd_ok  = ({1'b0, cnt_nx} + 5'd1) >= 5'(DEBOUNCE);
        evt_set = '0;
        if (state == S_UPD && !timed_out && upd_ok)
            evt_set[pad] = sample & ~stable[pad];
        evt_clr = '0;
        if (avs_write && avs_address == 2'd2)
            evt_clr = {avs_writedata[27:16], avs_writedata[11:0]};
    end

    // Absent pad forgets its history so it re-debounces from scratch when it returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable  <= '0;
            last    <= '0;
            cnt     <= '0;
            present <= '0;
        end else if (state == S_UPD) begin
            if (timed_out) begin
                present[pad] <= 1'b0;
                stable[pad]  <= '0;
                cnt[pad]     <= '0;
                last[pad]    <= '0;
            end else begin
                present[pad] <= 1'b1;
                cnt[pad]     <= cnt_nx;
                last[pad]    <= sample;
                if (upd_ok) stable[pad] <= sample;
            end
        end
    end

    // Set wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) evt <= '0;
        else        evt <= (evt & ~evt_clr) | evt_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  enable <= 1'b1;
        else if (avs_write && avs_address == 2'd3)   enable <= avs_writedata[0];
    end

`ifdef GAMEPAD_POLL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (avs_write && avs_address == 2'd3) irq_en <= avs_writedata[1];
            irq <= irq_en & (|evt);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0: rd_mux[11:0] = stable[0];
            2'd1: rd_mux[11:0] = stable[1];
            2'd2: begin
                rd_mux[11:0]  = evt[0];
                rd_mux[27:16] = evt[1];
            end
            default: begin
                rd_mux[0]    = enable;
                rd_mux[1]    = irq_en;
                rd_mux[2]    = present[0];
                rd_mux[3]    = present[1];
                rd_mux[15:8] = frame;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        avs_readdata <= '0;
        else if (avs_read) avs_readdata <= rd_mux;
    end
endmodule

// File: tb/tb_gamepad_poll_scheduler.sv
// Bench for gamepad_poll_scheduler: pad-response model, register-read scoreboard, table vectors.
module tb_gamepad_poll_scheduler;
    localparam int PP = 100;
    localparam int DB = 2;
    localparam int TO = 40;
`ifdef GAMEPAD_POLL_IRQ_EN
    localparam logic IRQ_B = 1'b1;
`else
    localparam logic IRQ_B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_req, scan_sel, scan_done = 1'b0, avs_read = 1'b0, avs_write = 1'b0, irq;
    logic [11:0] scan_btn = 12'hFFF;
    logic [1:0]  avs_address = 2'd0;
    logic [31:0] avs_writedata = '0, avs_readdata;

    gamepad_poll_scheduler #(.POLL_PERIOD(PP), .DEBOUNCE(DB), .SCAN_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .scan_req(scan_req), .scan_sel(scan_sel),
        .scan_done(scan_done), .scan_btn(scan_btn), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc;
    int req_cyc = -1;
    logic exp_sel = 1'b0;
    logic [1:0][11:0] pad_val = '0;
    logic [1:0] absent = '0;
    logic [31:0] exp_q[$];

    typedef struct { logic [1:0] addr; logic [31:0] exp; } vec_t;
    vec_t tbl[12];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Pad model: scan_done 20 cycles after scan_req, unless that pad is absent.
    always begin : pad_model
        logic sel;
        @(negedge clk);
        if (rst_n && scan_req) begin
            chk("scan_sel", {31'b0, scan_sel}, {31'b0, exp_sel});
            exp_sel = ~exp_sel;
            if (req_cyc < 0) req_cyc = cyc;
            sel = scan_sel;
            @(negedge clk);
            chk("req_pulse", {31'b0, scan_req}, 32'd0);
            repeat (18) @(posedge clk);
            #1;
            if (!absent[sel]) begin
                scan_btn  = pad_val[sel];
                scan_done = 1'b1;
                @(posedge clk);
                #1;
                scan_done = 1'b0;
                scan_btn  = 12'hFFF;
            end
        end
    end

    task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        avs_address = a; avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        chk(nm, avs_readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input string nm);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (scan_done && scan_sel == 1'b0) seen = 1;
        end
        if (!seen) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic run_tbl(input int lo, input int hi, input string nm);
        for (int i = lo; i <= hi; i++) rd($sformatf("%s[%0d]", nm, i - lo), tbl[i].addr, tbl[i].exp);
    endtask

    initial begin
        tbl[0]  = '{2'd0, 32'h0};        tbl[1]  = '{2'd1, 32'h0};
        tbl[2]  = '{2'd2, 32'h0};        tbl[3]  = '{2'd3, 32'h1};
        tbl[4]  = '{2'd0, 32'h010};      tbl[5]  = '{2'd1, 32'h400};
        tbl[6]  = '{2'd2, 32'h04000010}; tbl[7]  = '{2'd3, 32'h20D};
        tbl[8]  = '{2'd0, 32'h0};        tbl[9]  = '{2'd1, 32'h0};
        tbl[10] = '{2'd2, 32'h0};        tbl[11] = '{2'd3, 32'h1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, scan_req}, 0);
        chk("rst_sel", {31'b0, scan_sel}, 0);
        chk("rst_rdata", avs_readdata, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        rst_n = 1'b1;
        run_tbl(0, 3, "reset_regs");

        // Constant presses; debounce of 2 needs two frames.
        pad_val[0] = 12'h010; pad_val[1] = 12'h400;
        wait_until(160);
        rd("f1_addr0", 2'd0, 32'h0);
        rd("f1_addr2", 2'd2, 32'h0);
        rd("f1_addr3", 2'd3, 32'h10D);
        wait_until(260);
        run_tbl(4, 7, "f2_regs");
        chk("f2_irq", {31'b0, irq}, 0);

        // Debounce sequence 0x001, 0x002, 0x002.
        wr(2'd2, 32'hFFFF_FFFF);
        rd("clr_addr2", 2'd2, 32'h0);
        pad_val[0] = 12'h001;
        wait_until(360);
        rd("db1_addr0", 2'd0, 32'h010);
        pad_val[0] = 12'h002;
        wait_until(460);
        rd("db2_addr0", 2'd0, 32'h010);
        wait_until(560);
        rd("db3_addr0", 2'd0, 32'h002);
        rd("db3_addr2", 2'd2, 32'h002);

        // Set/clear collision on the UPD cycle of pad0.
        wr(2'd2, 32'hFFFF_FFFF);
        pad_val[0] = 12'h010;
        wait_until(660);
        wait_done0("wait_c");
        @(posedge clk); #1;
        avs_address = 2'd2; avs_writedata = 32'h10; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
        rd("setwins_addr2", 2'd2, 32'h10);
        wr(2'd2, 32'h10);
        rd("w1c_addr2", 2'd2, 32'h0);
        wait_until(760);

        // Interrupt on Start press.
        wr(2'd3, 32'h3);
        rd("ctl_irqen", 2'd3, 32'h70D | {30'b0, IRQ_B, 1'b0});
        pad_val[0] = 12'h400;
        wait_until(860);
        wait_done0("wait_d");
        @(posedge clk);
        @(posedge clk); #1;
        chk("irq_pre", {31'b0, irq}, 0);
        @(posedge clk); #1;
        chk("irq_set", {31'b0, irq}, {31'b0, IRQ_B});
        rd("irq_addr2", 2'd2, 32'h400);
        @(posedge clk); #1;
        avs_address = 2'd2; avs_writedata = 32'h400; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
        chk("irq_hold", {31'b0, irq}, {31'b0, IRQ_B});
        @(posedge clk); #1;
        chk("irq_clr", {31'b0, irq}, 0);
        wait_until(960);

        // Pad1 absent: timeout, then returns and must re-debounce.
        wr(2'd3, 32'h1);
        absent[1] = 1'b1;
        wait_until(1080);
        rd("to_addr1", 2'd1, 32'h0);
        rd("to_addr2", 2'd2, 32'h0);
        rd("to_addr3", 2'd3, 32'hA05);
        absent[1] = 1'b0;
        wait_until(1160);
        rd("back_addr3", 2'd3, 32'hB0D);
        rd("back_addr1", 2'd1, 32'h0);
        rd("back_addr2", 2'd2, 32'h0);

        // Reset during pad0 WAIT.
        wait_until(1210);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, scan_req}, 0);
        chk("mid_rst_sel", {31'b0, scan_sel}, 0);
        chk("mid_rst_rdata", avs_readdata, 0);
        chk("mid_rst_irq", {31'b0, irq}, 0);
        exp_sel = 1'b0;
        req_cyc = -1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_tbl(8, 11, "post_rst");
        wait_until(110);
        chk("first_req_cyc", req_cyc, 100);
        wait_until(150);
        rd("post_rst_addr3", 2'd3, 32'h10D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gamepad_poll_scheduler.md
Name: gamepad_poll_scheduler

Overview:
- Sequences periodic scans of two Genesis-style pads that share one scan engine (the pad-pin decoder) through an external pin mux driven by scan_sel.
- Per-pad debounce and stable button state; sticky press-event flags.
- Exposes everything to the Nios/VPU CPU through a 4-word Avalon-MM slave with an optional interrupt.

Parameters:
- POLL_PERIOD, 1666667: clk cycles between poll ticks (60 Hz at 100 MHz).
- DEBOUNCE, 2: consecutive identical samples (1..15) required before stable state updates.
- SCAN_TIMEOUT, 16383: max cycles waiting for scan_done before the pad is declared absent.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- scan_req  out  1  one-cycle pulse: start scan of the pad selected by scan_sel
- scan_sel  out  1  pad index (0/1) to pin mux; stable from scan_req through scan_done
- scan_done  in  1  one-cycle pulse: scan_btn valid
- scan_btn  in  12  active-high buttons {Mode,Start,Z,Y,X,C,B,A,Right,Left,Down,Up} [11:0]
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data
- irq  out  1  level interrupt

Interface: one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset values:
  - Outputs: scan_req=0, scan_sel=0, avs_readdata=0, irq=0.
  - Internal: all state/event/present/frame registers 0; enable=1, irq_en=0; poll counter 0.
- Poll counter:
  - Runs 0..POLL_PERIOD-1 and wraps; tick when count==POLL_PERIOD-1.
  - Counter always runs, even while a scan is active.
- FSM states:
  - IDLE: on tick and enable=1 -> REQ with pad=0. A tick while not in IDLE is dropped.
  - REQ: scan_req=1 for exactly one cycle, scan_sel=pad -> WAIT; timeout counter cleared.
  - WAIT:
    - scan_done -> UPD; sample scan_btn captured this cycle.
    - Timeout counter reaching SCAN_TIMEOUT -> UPD with timeout flag.
    - scan_done on the timeout cycle counts as done.
  - UPD: apply debounce/events for the pad.
    - pad=0 -> REQ with pad=1.
    - pad=1 -> IDLE; frame counter += 1 (8-bit, wraps 255->0).
- Debounce per pad:
  - sample==last_sample: cnt saturates at 15, else cnt+1. Otherwise cnt=0.
  - last_sample<=sample in both cases.
  - When cnt+1 (post-update) >= DEBOUNCE: new_stable=sample; press_evt |= new_stable & ~stable; stable<=new_stable.
  - DEBOUNCE=1: immediate update.
- Timeout:
  - present[pad]<=0, stable<=0, cnt<=0, last_sample<=0; no events raised.
  - Successful scan sets present[pad]<=1.
- Enable cleared mid-scan: current pair of scans completes; no new REQ until enable=1.
- Register map, read latency 1 cycle (avs_readdata registered, holds last value when no read):
  - 0: [11:0] pad0 stable, RO.
  - 1: [11:0] pad1 stable, RO.
  - 2: [11:0] pad0 press events, [27:16] pad1 press events; write-1-to-clear. Set and clear of the same bit in the same cycle: set wins.
  - 3: control/status:
    - bit0 enable RW
    - bit1 irq_en RW
    - bit2 present0 RO
    - bit3 present1 RO
    - [15:8] frame counter RO
    - Writes affect bits 1:0 only.
- Unused bits read 0; writes to RO addresses ignored.
- irq: registered, = irq_en & |events; asserts the cycle after the event register becomes non-zero.

Optional Feature:
- GAMEPAD_POLL_IRQ_EN
  - Defined: irq as specified; irq_en bit RW.
  - Undefined: irq tied 0; irq_en reads 0 and ignores writes; all other behaviour identical.

Test Plan:
- POLL_PERIOD=100, DEBOUNCE=1; model returns scan_done 20 cycles after scan_req with pad0=12'h010, pad1=12'h400 -> scan_sel 0 then 1; addr0=0x010, addr1=0x400, addr2=0x04000010, frame counter=1, present bits=11.
- DEBOUNCE=2; pad0 samples 0x001, 0x002, 0x002 over three frames -> addr0 stays 0 after frames 1-2, becomes 0x002 after frame 3; only bit1 press event set.
- Write addr2=0x00000010 in the same cycle UPD sets pad0 bit4 again -> bit4 remains 1; separate write clears it -> addr2 reads 0.
- Pad1 never returns scan_done -> after SCAN_TIMEOUT cycles present1=0, addr1=0, no pad1 events, FSM back in IDLE, next tick scans pad0 again.
- irq_en=1; pad0 press Start (0x400) -> irq=1 one cycle after event set; W1C 0x400 -> irq=0 next cycle; with GAMEPAD_POLL_IRQ_EN undefined, irq stays 0 throughout.
- Assert rst_n low during WAIT -> all outputs and registers return to reset values immediately; after release, first scan_req only after a full POLL_PERIOD.
